// File: rtl/if_id_stage_pkg.sv
// Shared CPU definitions: control opcodes, the default NOP word and the
// control-class decode used by the IF/ID stage and its hazard unit.
package if_id_stage_pkg;

   localparam logic [5:0]  OP_BEQ            = 6'b000100;
   localparam logic [5:0]  OP_BNE            = 6'b000101;
   localparam logic [5:0]  OP_J              = 6'b000010;
   localparam logic [5:0]  OP_JAL            = 6'b000011;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam logic [15:0] CNT_MAX           = 16'hFFFF;

   typedef enum logic [1:0] {
      CTL_NONE = 2'd0,
      CTL_BEQ  = 2'd1,
      CTL_BNE  = 2'd2,
      CTL_JUMP = 2'd3
   } ctl_e;

   function automatic ctl_e decode_ctl(input logic [5:0] opcode);
      ctl_e ctl;
      case (opcode)
         OP_BEQ:       ctl = CTL_BEQ;
         OP_BNE:       ctl = CTL_BNE;
         OP_J, OP_JAL: ctl = CTL_JUMP;
         default:      ctl = CTL_NONE;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/if_id_stage_hazard_unit.sv
// Hazard detection for the ID stage: load-use stalls for all non-jump
// instructions plus the extra EX/MEM dependency stalls branches need.
module hazard_unit
   import if_id_stage_pkg::*;
(
   input  logic       i_valid,
   input  logic       i_reset,
   input  ctl_e       i_ctl,
   input  logic       i_mem_read_ex,
   input  logic       i_reg_write_ex,
   input  logic [4:0] i_write_reg_ex,
   input  logic       i_mem_read_mem,
   input  logic [4:0] i_write_reg_mem,
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rt,
   output logic       o_stall
);

   logic w_ex_match;
   logic w_mem_match;
   logic w_load_use;
   logic w_branch_dep;

   assign w_ex_match  = (i_write_reg_ex != 5'd0) &&
                        ((i_write_reg_ex == i_rs) || (i_write_reg_ex == i_rt));
   assign w_mem_match = (i_write_reg_mem != 5'd0) &&
                        ((i_write_reg_mem == i_rs) || (i_write_reg_mem == i_rt));

   // Branches compare in ID, so they must also wait on ALU results and MEM-stage loads.
   always_comb begin
      w_load_use   = 1'b0;
      w_branch_dep = 1'b0;
      if (i_ctl == CTL_JUMP) begin
         w_load_use   = 1'b0;
         w_branch_dep = 1'b0;
      end else begin
         w_load_use = i_mem_read_ex && w_ex_match;
         if ((i_ctl == CTL_BEQ) || (i_ctl == CTL_BNE)) begin
            w_branch_dep = (i_reg_write_ex && w_ex_match) || (i_mem_read_mem && w_mem_match);
         end else begin
            w_branch_dep = 1'b0;
         end
      end
   end

   assign o_stall = i_valid && !i_reset && (w_load_use || w_branch_dep);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with ID-stage branch/jump resolution, hazard
// stalling and saturating stall/flush performance counters.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction_if,
   input  logic [31:0] PC_if,
   input  logic        IF_flush,
   input  logic        MemRead_ex,
   input  logic        RegWrite_ex,
   input  logic [4:0]  WriteReg_ex,
   input  logic        MemRead_mem,
   input  logic [4:0]  WriteReg_mem,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] Instruction_id,
   output logic [31:0] PCplus4_id,
   output logic        valid_id,
   output logic [4:0]  rs_id,
   output logic [4:0]  rt_id,
   output logic        Branch,
   output logic        Jump,
   output logic [31:0] JumpAddr,
   output logic        IFWrite,
   output logic        ID_bubble,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;
   logic [15:0] r_stall_count;
   logic [15:0] r_flush_count;

   ctl_e        w_ctl;
   logic        w_stall;
   logic        w_eq;
   logic [31:0] w_branch_target;
   logic [31:0] w_jump_target;

   assign rs_id = r_instr[25:21];
   assign rt_id = r_instr[20:16];
   assign w_ctl = decode_ctl(r_instr[31:26]);

   hazard_unit u_hazard (
      .i_valid         (r_valid),
      .i_reset         (reset),
      .i_ctl           (w_ctl),
      .i_mem_read_ex   (MemRead_ex),
      .i_reg_write_ex  (RegWrite_ex),
      .i_write_reg_ex  (WriteReg_ex),
      .i_mem_read_mem  (MemRead_mem),
      .i_write_reg_mem (WriteReg_mem),
      .i_rs            (rs_id),
      .i_rt            (rt_id),
      .o_stall         (w_stall)
   );

   assign w_eq            = (rs_data == rt_data);
   assign w_branch_target = r_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_jump_target   = {r_pc4[31:28], r_instr[25:0], 2'b00};

   // A stalled branch must not resolve: its operands are not yet final.
   assign Branch    = r_valid && !reset && !w_stall &&
                      (((w_ctl == CTL_BEQ) && w_eq) || ((w_ctl == CTL_BNE) && !w_eq));
   assign Jump      = r_valid && !reset && (w_ctl == CTL_JUMP);
   assign JumpAddr  = Jump ? w_jump_target : w_branch_target;
   assign IFWrite   = !w_stall;
   assign ID_bubble = w_stall;

   // IF/ID register: reset, then flush, then hold on stall, else load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (IF_flush) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (w_stall) begin
         r_instr <= r_instr;
         r_pc4   <= r_pc4;
         r_valid <= r_valid;
      end else begin
         r_instr <= Instruction_if;
         r_pc4   <= PC_if + 32'd4;
         r_valid <= 1'b1;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_count <= 16'd0;
         r_flush_count <= 16'd0;
      end else begin
         if (w_stall && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end else begin
            r_stall_count <= r_stall_count;
         end
         if (IF_flush && (r_flush_count != CNT_MAX)) begin
            r_flush_count <= r_flush_count + 16'd1;
         end else begin
            r_flush_count <= r_flush_count;
         end
      end
   end

   assign Instruction_id = r_instr;
   assign PCplus4_id     = r_pc4;
   assign valid_id       = r_valid;
   assign stall_count    = r_stall_count;
   assign flush_count    = r_flush_count;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a spec-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_if_id_stage;

   localparam logic [31:0] NOP  = 32'h0000_0020;
   localparam logic [31:0] ADDI = 32'h2001_0005;
   localparam logic [31:0] ADD  = 32'h0022_1820;
   localparam logic [31:0] BEQ  = 32'h1022_0003;
   localparam logic [31:0] BNE  = 32'h1485_FFFF;
   localparam logic [31:0] JMP  = 32'h0800_0010;
   localparam logic [31:0] JAL  = 32'h0C63_0000;

   logic        clk;
   logic        reset;
   logic [31:0] Instruction_if, PC_if;
   logic        IF_flush, MemRead_ex, RegWrite_ex, MemRead_mem;
   logic [4:0]  WriteReg_ex, WriteReg_mem;
   logic [31:0] rs_data, rt_data;
   logic [31:0] Instruction_id, PCplus4_id, JumpAddr;
   logic        valid_id, Branch, Jump, IFWrite, ID_bubble;
   logic [4:0]  rs_id, rt_id;
   logic [15:0] stall_count, flush_count;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   logic [31:0] m_instr, m_pc4;
   logic        m_valid;
   logic [15:0] m_sc, m_fc;

   if_id_stage #(.NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .PC_if(PC_if),
      .IF_flush(IF_flush), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
      .WriteReg_ex(WriteReg_ex), .MemRead_mem(MemRead_mem), .WriteReg_mem(WriteReg_mem),
      .rs_data(rs_data), .rt_data(rt_data), .Instruction_id(Instruction_id),
      .PCplus4_id(PCplus4_id), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
      .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr), .IFWrite(IFWrite),
      .ID_bubble(ID_bubble), .stall_count(stall_count), .flush_count(flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model expectations, derived from the instruction held in the model's ID slot.
   function automatic logic is_br();
      return (m_instr[31:26] == 6'd4) || (m_instr[31:26] == 6'd5);
   endfunction

   function automatic logic is_jmp();
      return (m_instr[31:26] == 6'd2) || (m_instr[31:26] == 6'd3);
   endfunction

   function automatic logic exp_stall();
      logic [4:0] rs, rt;
      logic lu, bd;
      rs = m_instr[25:21];
      rt = m_instr[20:16];
      lu = !is_jmp() && MemRead_ex && WriteReg_ex != 5'd0 && (WriteReg_ex == rs || WriteReg_ex == rt);
      bd = is_br() && ((RegWrite_ex && WriteReg_ex != 5'd0 && (WriteReg_ex == rs || WriteReg_ex == rt)) ||
                       (MemRead_mem && WriteReg_mem != 5'd0 && (WriteReg_mem == rs || WriteReg_mem == rt)));
      return m_valid && !reset && (lu || bd);
   endfunction

   function automatic logic exp_branch();
      logic taken;
      taken = (m_instr[31:26] == 6'd4) ? (rs_data == rt_data) :
              (m_instr[31:26] == 6'd5) ? (rs_data != rt_data) : 1'b0;
      return m_valid && !reset && !exp_stall() && taken;
   endfunction

   function automatic logic exp_jump();
      return m_valid && !reset && is_jmp();
   endfunction

   function automatic logic [31:0] exp_target();
      if (exp_jump()) return {m_pc4[31:28], m_instr[25:0], 2'b00};
      return m_pc4 + ({{16{m_instr[15]}}, m_instr[15:0]} * 32'd4);
   endfunction

   // Model state advance on every rising edge.
   always @(posedge clk) begin
      if (reset) begin
         m_instr <= NOP; m_pc4 <= 32'd0; m_valid <= 1'b0; m_sc <= 16'd0; m_fc <= 16'd0;
      end else begin
         if (IF_flush) begin
            m_instr <= NOP; m_pc4 <= 32'd0; m_valid <= 1'b0;
         end else if (!exp_stall()) begin
            m_instr <= Instruction_if; m_pc4 <= PC_if + 32'd4; m_valid <= 1'b1;
         end
         if (exp_stall() && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
         if (IF_flush && m_fc != 16'hFFFF) m_fc <= m_fc + 16'd1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_instr", Instruction_id, m_instr);
         chk("m_pc4", PCplus4_id, m_pc4);
         chk("m_valid", {31'd0, valid_id}, {31'd0, m_valid});
         chk("m_rs", {27'd0, rs_id}, {27'd0, m_instr[25:21]});
         chk("m_rt", {27'd0, rt_id}, {27'd0, m_instr[20:16]});
         chk("m_ifwrite", {31'd0, IFWrite}, {31'd0, !exp_stall()});
         chk("m_bubble", {31'd0, ID_bubble}, {31'd0, exp_stall()});
         chk("m_branch", {31'd0, Branch}, {31'd0, exp_branch()});
         chk("m_jump", {31'd0, Jump}, {31'd0, exp_jump()});
         if (exp_branch() || exp_jump()) chk("m_jaddr", JumpAddr, exp_target());
         chk("m_scount", {16'd0, stall_count}, {16'd0, m_sc});
         chk("m_fcount", {16'd0, flush_count}, {16'd0, m_fc});
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; Instruction_if = 32'd0; PC_if = 32'd0; IF_flush = 1'b0;
      MemRead_ex = 1'b0; RegWrite_ex = 1'b0; WriteReg_ex = 5'd0;
      MemRead_mem = 1'b0; WriteReg_mem = 5'd0; rs_data = 32'd0; rt_data = 32'd0;
      nxt();
      chk_en = 1'b1;
      #1;
      chk("rst_ifwrite", {31'd0, IFWrite}, 32'd1);
      chk("rst_bubble", {31'd0, ID_bubble}, 32'd0);
      nxt();
      chk("rst_instr", Instruction_id, NOP);
      chk("rst_pc4", PCplus4_id, 32'd0);
      chk("rst_valid", {31'd0, valid_id}, 32'd0);
      chk("rst_cnt", {stall_count, flush_count}, 32'd0);

      // Plain load.
      reset = 1'b0; Instruction_if = ADDI; PC_if = 32'h40;
      nxt();
      chk("load_pc4", PCplus4_id, 32'h44);
      chk("load_valid", {31'd0, valid_id}, 32'd1);
      chk("load_instr", Instruction_id, ADDI);
      #1 chk("load_ifwrite", {31'd0, IFWrite}, 32'd1);
      Instruction_if = ADD; PC_if = 32'h44;
      nxt();

      // Non-branch ignores RegWrite_ex and MEM-stage loads.
      RegWrite_ex = 1'b1; WriteReg_ex = 5'd2; MemRead_mem = 1'b1; WriteReg_mem = 5'd1;
      Instruction_if = ADD; PC_if = 32'h48;
      #1 chk("nobr_ifwrite", {31'd0, IFWrite}, 32'd1);
      nxt();

      // Load-use stall.
      RegWrite_ex = 1'b0; MemRead_mem = 1'b0; WriteReg_mem = 5'd0;
      MemRead_ex = 1'b1; WriteReg_ex = 5'd1; Instruction_if = 32'd0; PC_if = 32'h4C;
      #1;
      chk("lu_ifwrite", {31'd0, IFWrite}, 32'd0);
      chk("lu_bubble", {31'd0, ID_bubble}, 32'd1);
      nxt();
      chk("lu_hold", Instruction_id, ADD);
      chk("lu_hold_pc4", PCplus4_id, 32'h4C);
      chk("lu_scount", {16'd0, stall_count}, 32'd1);
      MemRead_ex = 1'b0; WriteReg_ex = 5'd0; Instruction_if = BEQ; PC_if = 32'hFC;
      #1 chk("lu_clear", {31'd0, IFWrite}, 32'd1);
      nxt();

      // Taken beq and flush.
      rs_data = 32'd7; rt_data = 32'd7; IF_flush = 1'b1; Instruction_if = 32'hDEAD_BEEF; PC_if = 32'h100;
      #1;
      chk("beq_branch", {31'd0, Branch}, 32'd1);
      chk("beq_addr", JumpAddr, 32'h10C);
      nxt();
      chk("flush_valid", {31'd0, valid_id}, 32'd0);
      chk("flush_instr", Instruction_id, NOP);
      chk("flush_fcount", {16'd0, flush_count}, 32'd1);

      // bne with EX dependency stalls, then resolves.
      IF_flush = 1'b0; Instruction_if = BNE; PC_if = 32'h200;
      nxt();
      RegWrite_ex = 1'b1; WriteReg_ex = 5'd4; rs_data = 32'd1; rt_data = 32'd2;
      Instruction_if = 32'd0; PC_if = 32'h204;
      #1;
      chk("bne_stall", {31'd0, IFWrite}, 32'd0);
      chk("bne_nobranch", {31'd0, Branch}, 32'd0);
      nxt();
      chk("bne_hold", Instruction_id, BNE);
      chk("bne_scount", {16'd0, stall_count}, 32'd2);
      RegWrite_ex = 1'b0; WriteReg_ex = 5'd0; IF_flush = 1'b1;
      #1;
      chk("bne_branch", {31'd0, Branch}, 32'd1);
      chk("bne_addr", JumpAddr, 32'h200);
      nxt();
      chk("bne_fcount", {16'd0, flush_count}, 32'd2);

      // j never stalls.
      IF_flush = 1'b0; Instruction_if = JMP; PC_if = 32'hA000_0000;
      nxt();
      MemRead_ex = 1'b1; WriteReg_ex = 5'd1; IF_flush = 1'b1; Instruction_if = 32'd0;
      #1;
      chk("j_jump", {31'd0, Jump}, 32'd1);
      chk("j_addr", JumpAddr, 32'hA000_0040);
      chk("j_ifwrite", {31'd0, IFWrite}, 32'd1);
      chk("j_nobranch", {31'd0, Branch}, 32'd0);
      nxt();

      // jal whose index bits alias a matching register still does not stall.
      IF_flush = 1'b0; MemRead_ex = 1'b0; WriteReg_ex = 5'd0; Instruction_if = JAL; PC_if = 32'h300;
      nxt();
      MemRead_ex = 1'b1; WriteReg_ex = 5'd3; IF_flush = 1'b1; Instruction_if = 32'd0;
      #1;
      chk("jal_jump", {31'd0, Jump}, 32'd1);
      chk("jal_addr", JumpAddr, 32'h018C_0000);
      chk("jal_bubble", {31'd0, ID_bubble}, 32'd0);
      nxt();
      chk("jal_fcount", {16'd0, flush_count}, 32'd4);

      // Reset during a MEM-dependency branch stall.
      IF_flush = 1'b0; MemRead_ex = 1'b0; WriteReg_ex = 5'd0; Instruction_if = BEQ; PC_if = 32'hFC;
      nxt();
      MemRead_mem = 1'b1; WriteReg_mem = 5'd2; rs_data = 32'd7; rt_data = 32'd7;
      #1;
      chk("mem_stall", {31'd0, IFWrite}, 32'd0);
      chk("mem_nobranch", {31'd0, Branch}, 32'd0);
      nxt();
      reset = 1'b1;
      #1;
      chk("rs_branch", {31'd0, Branch}, 32'd0);
      chk("rs_jump", {31'd0, Jump}, 32'd0);
      chk("rs_ifwrite", {31'd0, IFWrite}, 32'd1);
      chk("rs_bubble", {31'd0, ID_bubble}, 32'd0);
      nxt();
      chk("rs_valid", {31'd0, valid_id}, 32'd0);
      chk("rs_instr", Instruction_id, NOP);
      chk("rs_cnt", {stall_count, flush_count}, 32'd0);

      // Stall counter saturation.
      reset = 1'b0; MemRead_mem = 1'b0; WriteReg_mem = 5'd0; Instruction_if = ADD; PC_if = 32'h500;
      nxt();
      MemRead_ex = 1'b1; WriteReg_ex = 5'd2;
      repeat (65540) nxt();
      chk("sat_scount", {16'd0, stall_count}, 32'h0000_FFFF);
      chk("sat_hold", Instruction_id, ADD);
      MemRead_ex = 1'b0; WriteReg_ex = 5'd0;
      nxt();
      nxt();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
